addsub_arbiter: RTL

- Sequences and shares one W-bit ripple add/subtract datapath between two requesters.
- Arbitrates between the two requesters round-robin and latches the winner's operands.
- Executes the operation in one registered cycle, then holds the result until the consumer accepts it.
- Sits between two operand sources and a single result consumer; it is the only driver of the shared adder/subtractor.

---
 rtl/addsub_arbiter_if.sv | 43 ++++
 rtl/addsub_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/addsub_arbiter_if.sv
// Bundle for the two requester ports and the single response port of addsub_arbiter.
// Optional ovf signal is present only when ADDSUB_ARB_OVF_EN is defined.
interface addsub_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             mode0;
    logic             gnt0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             mode1;
    logic             gnt1;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             rsp_valid;
    logic             rsp_id;
    logic             rsp_ready;
    logic             busy;
`ifdef ADDSUB_ARB_OVF_EN
    logic             ovf;
`endif

    // Requester/consumer side
    modport master (
        output req0, a0, b0, mode0, req1, a1, b1, mode1, rsp_ready,
        input  gnt0, gnt1, res, cout, rsp_valid, rsp_id, busy
`ifdef ADDSUB_ARB_OVF_EN
        , input ovf
`endif
    );

    // Arbiter side
    modport slave (
        input  req0, a0, b0, mode0, req1, a1, b1, mode1, rsp_ready,
        output gnt0, gnt1, res, cout, rsp_valid, rsp_id, busy
`ifdef ADDSUB_ARB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit add/subtract datapath between two requesters.
// Define ADDSUB_ARB_OVF_EN to add the registered two's-complement overflow flag (ovf).
module addsub_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    addsub_arbiter_if.slave  bus
);
    localparam int unsigned SW  = WIDTH + 1;
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             mode_q, mode_d, id_q, id_d, last_q, last_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             cout_q, cout_d, rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d, busy_q, busy_d;
    logic [WIDTH-1:0] b_x;
    logic [SW-1:0]    sum;
    logic             pick1;
`ifdef ADDSUB_ARB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Subtraction is a + ~b + 1; carry out of the MSB doubles as the no-borrow flag
    always_comb begin
        b_x = b_q ^ {WIDTH{mode_q}};
        sum = SW'(a_q) + SW'(b_x) + SW'(mode_q);
    end

    // Requester 1 wins when alone, or on a tie when requester 0 was served last
    assign pick1 = bus.req1 & (~bus.req0 | ~last_q);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        id_d        = id_q;
        last_d      = last_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        res_d       = res_q;
        cout_d      = cout_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
`ifdef ADDSUB_ARB_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    id_d    = pick1;
                    a_d     = pick1 ? bus.a1 : bus.a0;
                    b_d     = pick1 ? bus.b1 : bus.b0;
                    mode_d  = pick1 ? bus.mode1 : bus.mode0;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d       = sum[WIDTH-1:0];
                cout_d      = sum[WIDTH];
`ifdef ADDSUB_ARB_OVF_EN
                // Carry into the MSB recovered from the MSB sum bit
                ovf_d       = (a_q[MSB] ^ b_x[MSB] ^ sum[MSB]) ^ sum[WIDTH];
`endif
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_d      = rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            id_q        <= id_d;
            last_q      <= last_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
`ifdef ADDSUB_ARB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.res       = res_q;
    assign bus.cout      = cout_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = busy_q;
`ifdef ADDSUB_ARB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule
